// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULO up/down counter with clear, load, compare and
// cascade outputs. count/carry/match/load_err are registered; tc is
// combinational so a chain of stages advances on the same edge.
module mod_counter #(
    parameter int WIDTH  = 8,
    parameter int MODULO = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             match,
    output logic             load_err
);

    // Reject a modulus the counter cannot represent.
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
        $error("mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    // Top value fits in WIDTH bits even when MODULO == 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             lerr_next;
    logic             match_next;

    assign at_max  = (count == MAX);
    assign at_zero = (count == '0);

    // Terminal count: the step about to happen on this edge is a wrap.
    assign tc = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));

    // Next count with clr > load > en priority; wrap handled explicitly so
    // no increment ever needs a bit beyond WIDTH.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        lerr_next  = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            if (load_val > MAX) begin
                count_next = MAX;
                lerr_next  = 1'b1;
            end else begin
                count_next = load_val;
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_next = MAX;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
        // Compared against the value being registered, so match lines up
        // with count; cmp_val above MAX can never equal count_next.
        match_next = (count_next == cmp_val);
    end

    // State and one-cycle pulses; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            carry    <= 1'b0;
            match    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_next;
            carry    <= wrap_next;
            match    <= match_next;
            load_err <= lerr_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: the stimulus process pushes expected
// responses from an arithmetic reference model; a monitor pops and compares.
module tb_mod_counter;

    localparam int M = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [7:0] load_val = '0, cmp_val = '0;
    logic [7:0] count;
    logic       tc, carry, match, load_err;

    logic       casc_en = 1'b0;
    logic [7:0] s1_count, s2_count;
    logic       s1_tc, s1_carry, s1_match, s1_lerr;
    logic       s2_tc, s2_carry, s2_match, s2_lerr;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(8), .MODULO(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .count(count), .tc(tc),
        .carry(carry), .match(match), .load_err(load_err));

    mod_counter #(.WIDTH(8), .MODULO(10)) u_s1 (
        .clk(clk), .rst(rst), .en(casc_en), .up(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(8'd0), .cmp_val(8'd0), .count(s1_count), .tc(s1_tc),
        .carry(s1_carry), .match(s1_match), .load_err(s1_lerr));

    mod_counter #(.WIDTH(8), .MODULO(6)) u_s2 (
        .clk(clk), .rst(rst), .en(s1_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(8'd0), .cmp_val(8'd0), .count(s2_count), .tc(s2_tc),
        .carry(s2_carry), .match(s2_match), .load_err(s2_lerr));

    typedef struct {
        bit tc;
        int cnt;
        bit carry;
        bit match;
        bit lerr;
        int c1;
        int c2;
        bit c2carry;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   s2_carry_seen = 0;

    // reference model state
    int   mc = 0;
    int   c1 = 0;
    int   c2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at the falling edge and predict the
    // combinational tc now plus the registered outputs after the next edge.
    task automatic step(input bit r, input bit e, input bit u, input bit c,
                        input bit l, input int lv, input int cv, input bit ce);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; clr = c; load = l;
        load_val = 8'(lv); cmp_val = 8'(cv); casc_en = ce;
        if (!r) begin
            mc = 0; c1 = 0; c2 = 0;
        end
        x.tc = e && !c && !l && ((u && mc == M - 1) || (!u && mc == 0));
        x.carry = 0; x.lerr = 0; x.c2carry = 0;
        if (!r) begin
            mc = 0;
        end else if (c) begin
            mc = 0;
        end else if (l) begin
            if (lv > M - 1) begin
                mc = M - 1; x.lerr = 1;
            end else begin
                mc = lv;
            end
        end else if (e) begin
            if (u) begin
                x.carry = (mc == M - 1);
                mc = (mc + 1) % M;
            end else begin
                x.carry = (mc == 0);
                mc = (mc + M - 1) % M;
            end
        end
        x.cnt = mc;
        x.match = r && (mc == cv);
        if (r && ce) begin
            if (c1 == 9) begin
                x.c2carry = (c2 == 5);
                c2 = (c2 + 1) % 6;
            end
            c1 = (c1 + 1) % 10;
        end
        x.c1 = c1;
        x.c2 = c2;
        q.push_back(x);
    endtask

    // Monitor: tc just after inputs settle, registers just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tc", tc, x.tc);
                @(posedge clk);
                #1;
                chk("count", count, x.cnt);
                chk("carry", carry, x.carry);
                chk("match", match, x.match);
                chk("load_err", load_err, x.lerr);
                chk("s1_count", s1_count, x.c1);
                chk("s2_count", s2_count, x.c2);
                chk("s2_carry", s2_carry, x.c2carry);
                if (s2_carry) s2_carry_seen++;
            end
        end
    end

    initial begin
        int budget;
        // reset with en=1, cmp_val=0; tc only for a down step from 0
        #3;
        chk("reset_count", count, 0);
        chk("reset_match", match, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 5, 0, 0);
        // release and idle
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 0);

        // cascade 10 x 6 for 60 edges
        s2_carry_seen = 0;
        for (int i = 0; i < 60; i++) step(1, 0, 1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("s2_carry_pulses", s2_carry_seen, 1);

        // up wrap from 0 over 61 edges
        step(1, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) step(1, 1, 1, 0, 0, 0, 59, 0);

        // down borrow with compare at 59
        step(1, 0, 0, 0, 1, 2, 59, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 59, 0);

        // priority: clr beats load and en at 59, then an out-of-range load
        step(1, 0, 1, 0, 1, 59, 0, 0);
        step(1, 1, 1, 1, 1, 7, 0, 0);
        step(1, 0, 1, 0, 1, 70, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 255, 200, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(39, 0) != 0,
                 $urandom_range(3, 0) != 0,
                 $urandom_range(1, 0) == 1,
                 $urandom_range(19, 0) == 0,
                 $urandom_range(9, 0) == 0,
                 $urandom_range(255, 0),
                 ($urandom_range(3, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(59, 0),
                 $urandom_range(1, 0) == 1);
        end

        // async reset between edges at count 37 with match high
        step(1, 0, 1, 0, 1, 37, 37, 0);
        step(1, 0, 1, 0, 0, 0, 37, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        mc = 0; c1 = 0; c2 = 0;
        #1;
        chk("async_count", count, 0);
        chk("async_match", match, 0);
        step(0, 0, 1, 0, 0, 0, 37, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 0, 2, 0);

        // drain the scoreboard with a bounded wait
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk); #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter for the clock datapath: counts 0..MODULO-1 up or down with enable, synchronous clear and parallel load, and flags a programmable compare value. A combinational terminal-count output lets instances cascade into seconds/minutes/hours chains. A registered wrap pulse drives downstream timing logic.

## Interface

- WIDTH, 8, width of count, load_val and cmp_val.
- MODULO, 60, count range 0..MODULO-1; legal range 2 <= MODULO <= 2^WIDTH (elaboration error otherwise).

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  count enable; the counter advances one step per edge while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  load value.
- cmp_val  input  WIDTH  compare value for match.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational; used to cascade into the next stage's en.
- carry  output  1  registered one-cycle wrap pulse.
- match  output  1  registered compare flag.
- load_err  output  1  registered one-cycle pulse on an out-of-range load.

## Operation

- Per-edge priority is clr > load > en. If none is active, count holds.
- clr: count <= 0. No carry. load_err <= 0.
- load:
  - load_val <= MODULO-1: count <= load_val.
  - load_val > MODULO-1: count <= MODULO-1 (saturate) and load_err <= 1 for one cycle.
  - No carry in either case.
- en, up=1:
  - count == MODULO-1: count <= 0 and carry <= 1.
  - Otherwise: count <= count+1.
- en, up=0:
  - count == 0: count <= MODULO-1 and carry <= 1 (borrow).
  - Otherwise: count <= count-1.
- carry and load_err are 0 on every edge that does not set them, so they are exactly one cycle wide.
- tc = en & !clr & !load & ((up & count==MODULO-1) | (!up & count==0)).
  - tc is high during the cycle before the edge at which count wraps.
  - Connecting tc to the next stage's en gives a synchronous cascade.
- match <= (count_next == cmp_val) at every edge, where count_next is the value count takes at that same edge.
  - match is therefore high exactly during the cycles in which count == cmp_val, with no lag.
  - A change on cmp_val takes effect at the next edge.
  - cmp_val >= MODULO never matches.
- Arithmetic is unsigned WIDTH bits. Wrap is at MODULO, not 2^WIDTH. No intermediate value may exceed WIDTH bits when MODULO == 2^WIDTH.

## Timing

- Reset (rst low, asynchronous): count=0, carry=0, match=0, load_err=0.
  - match stays 0 even if cmp_val == 0 until the first edge after rst deasserts.
  - tc follows its equation and is 1 during reset only if en & !up & !clr & !load.
- Reset release is synchronised externally. The first count step is on the first rising edge with rst high and en high.
- Latency:
  - count, carry, match and load_err update one edge after the controlling inputs.
  - tc has zero latency (combinational from count, en, up, clr, load).
- Simultaneous events:
  - clr with load/en: clear wins, no carry.
  - load with en: load wins, no carry.
- Direction change mid-count takes effect at the next edge with no skipped or repeated value.
- rst asserted mid-count forces all registered outputs to reset values immediately, independent of clk.

## Test plan

- Reset/idle: rst low with en=1, cmp_val=0, then release, en=0 for 5 edges -> count=0 throughout; carry=0, load_err=0; match=0 during reset and 1 from the first edge after release.
- Up wrap (WIDTH=8, MODULO=60): up=1, en=1 from 0 for 61 edges ->
  - count runs 0..59,0,1;
  - tc high only while count==59;
  - carry high only in the cycle with count==0 after the wrap.
- Down borrow + cmp: up=0, load 2, then en=1, cmp_val=59 ->
  - count 2,1,0,59,58;
  - tc high at count==0;
  - carry one cycle at count==59;
  - match high exactly while count==59.
- Priority/load: same edge clr=1, load=1, load_val=7, en=1 at count=59 -> count=0, carry=0. Next edge load=1 only, load_val=70 -> count=59, load_err pulse, no carry.
- Cascade: two instances (MODULO=10, MODULO=6), stage-2 en = stage-1 tc, 60 edges -> stage 2 steps once per 10 edges and returns to 0/0 at edge 60; stage-2 carry pulses once.
- Async reset mid-count: count=37, assert rst between edges -> count=0 and match=0 immediately; count resumes from 0 after release.
